// File: rtl/tpu_pkg.sv
// Shared constants for the PE-array datapath: lane format and feeder FSM encoding.
package tpu_pkg;

   localparam int unsigned FP_W    = 32;
   localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

endpackage

// File: rtl/skew_delay_line.sv
// Register chain carrying {valid, data}; output appears DELAY+1 cycles after input.
module skew_delay_line #(
   parameter int unsigned DELAY = 0,
   parameter int unsigned W     = 32
) (
   input  logic         MCLK,
   input  logic         RST,
   input  logic         d_valid,
   input  logic [W-1:0] d_data,
   output logic         q_valid,
   output logic [W-1:0] q_data
);

   logic [W:0] stage_q [DELAY+1];

   always_ff @(posedge MCLK) begin
      if (RST) begin
         for (int k = 0; k <= int'(DELAY); k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= {d_valid, d_data};
         for (int k = 1; k <= int'(DELAY); k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign {q_valid, q_data} = stage_q[DELAY];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers N-lane vectors, launches one per cycle into a diagonal skew, and zero-flushes
// the PE array after the last vector of a job before pulsing done.
module systolic_skew_feeder
   import tpu_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned W     = FP_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic           MCLK,
   input  logic           RST,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_data,
   input  logic           in_last,
   output logic [N*W-1:0] out_lane,
   output logic [N-1:0]   out_lane_valid,
   output logic           busy,
   output logic           done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(2 * N);
   localparam logic [CW-1:0] FLUSH_LEN = CW'(2 * N - 1);

   // FIFO entry layout: {last, data}
   logic [N*W:0]   mem [DEPTH];
   logic [AW:0]    wr_ptr_q, rd_ptr_q, level;
   logic           full, empty, push, pop;
   logic [N*W-1:0] head_data;
   logic           head_last;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
   logic           last_pend_q, last_pend_d;

   assign level    = wr_ptr_q - rd_ptr_q;
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign in_ready = !full && !RST;
   assign push     = in_valid && in_ready;
   assign {head_last, head_data} = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge MCLK) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
      end
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         last_pend_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_q + {{AW{1'b0}}, push};
         rd_ptr_q    <= rd_ptr_q + {{AW{1'b0}}, pop};
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         last_pend_q <= last_pend_d;
      end
   end

   always_comb begin
      pop         = 1'b0;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      last_pend_d = last_pend_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop         = 1'b1;
               state_d     = STREAM;
               last_pend_d = head_last;
            end
         end
         STREAM: begin
            // A single-vector job was popped from IDLE; spend this cycle as a bubble.
            if (last_pend_q) begin
               last_pend_d = 1'b0;
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LEN;
            end else if (!empty) begin
               pop = 1'b1;
               if (head_last) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FLUSH_LEN;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_q <= CW'(1)) begin
               state_d     = IDLE;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - CW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            flush_cnt_d = '0;
            last_pend_d = 1'b0;
         end
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == FLUSH) && (flush_cnt_q == CW'(1)) && !RST;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0] launch_data;
      assign launch_data = pop ? head_data[i*W +: W] : W'(FP_ZERO);

      skew_delay_line #(
         .DELAY (i),
         .W     (W)
      ) u_delay (
         .MCLK    (MCLK),
         .RST     (RST),
         .d_valid (pop),
         .d_data  (launch_data),
         .q_valid (out_lane_valid[i]),
         .q_data  (out_lane[i*W +: W])
      );
   end

endmodule
